// File: rtl/ddr_ctrl_pkg.sv
// Shared definitions for the DDR3 channel controllers: address/length widths,
// FSM state encoding and the burst address stepping rule.
package ddr_ctrl_pkg;

    localparam int ADDR_W = 30;
    localparam int LEN_W  = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_BURST = 2'd2;

    // Step to the next burst; restart at beg_addr when the following burst
    // would run past end_addr. Done in ADDR_W+1 bits so the compare never wraps.
    function automatic logic [ADDR_W-1:0] next_burst_addr(
        input logic [ADDR_W-1:0] cur_addr,
        input logic [ADDR_W-1:0] inc,
        input logic [ADDR_W-1:0] beg_addr,
        input logic [ADDR_W-1:0] end_addr
    );
        logic [ADDR_W:0] nxt;
        logic [ADDR_W:0] last;
        nxt  = {1'b0, cur_addr} + {1'b0, inc};
        last = nxt + {1'b0, inc} - {{ADDR_W{1'b0}}, 1'b1};
        if (last > {1'b0, end_addr}) begin
            return beg_addr;
        end
        return nxt[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, read-valid strobe and occupancy count.
// A push while full is dropped unless a pop is accepted in the same cycle.
module sync_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic          rd_valid,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          wr_drop
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_ok;
    logic          rd_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rd_ok   = rd_en && !empty;
    assign wr_ok   = wr_en && (!full || rd_ok);
    assign wr_drop = wr_en && !wr_ok;

    always_ff @(posedge clk) begin
        if (wr_ok && !rst) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_ok;
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr];
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rd_channel_ctrl.sv
// Read-channel controller: prefetches DDR3 bursts through the read arbiter into
// a local FIFO and serves the buffered words to the user port.
module rd_channel_ctrl
    import ddr_ctrl_pkg::*;
#(
    parameter int AXI_WIDTH       = 64,
    parameter int FIFO_DEPTH      = 512,
    parameter int FIFO_ADDR_WIDTH = 9
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W-1:0]          rd_beg_addr,
    input  logic [ADDR_W-1:0]          rd_end_addr,
    input  logic [LEN_W-1:0]           rd_burst_len,
    input  logic                       rd_mem_enable,
    input  logic                       rd_en,
    output logic [AXI_WIDTH-1:0]       rd_data,
    output logic                       rd_valid,
    output logic                       rd_empty,
    output logic [FIFO_ADDR_WIDTH:0]   rd_data_count,
    input  logic                       rd_grant,
    output logic                       rd_req,
    output logic [ADDR_W-1:0]          rd_addr,
    output logic [LEN_W-1:0]           rd_len,
    input  logic [AXI_WIDTH-1:0]       axi_rd_data,
    input  logic                       axi_rd_vld,
    input  logic                       axi_rd_done,
    output logic                       rd_ovf,
    output logic                       rd_len_err,
    output logic [1:0]                 dbg_state
);

    localparam int BYTES_PER_BEAT = AXI_WIDTH / 8;

    // Handshakes: rd_req is held from REQ entry until the cycle rd_grant is seen;
    // rd_grant then stays high for the whole burst, and a beat is transferred on
    // every cycle with axi_rd_vld && rd_grant (no back-pressure). axi_rd_done
    // with rd_grant closes the burst. On the user side a pop happens on each
    // cycle with rd_en && !rd_empty, and rd_valid marks rd_data the cycle after.

    logic [1:0]                state;
    logic [8:0]                beat_cnt;
    logic [8:0]                real_len;
    logic [ADDR_W-1:0]         inc;
    logic [FIFO_ADDR_WIDTH:0]  free;
    logic                      fifo_full;
    logic                      fifo_drop;
    logic                      beat_in;
    logic                      push;
    logic                      beat_extra;
    logic                      beat_stray;

    assign real_len = {1'b0, rd_burst_len} + 9'd1;
    assign inc      = ADDR_W'(real_len) * ADDR_W'(BYTES_PER_BEAT);
    assign free     = (FIFO_ADDR_WIDTH+1)'(FIFO_DEPTH) - rd_data_count;

    assign beat_in    = (state == ST_BURST) && axi_rd_vld && rd_grant;
    assign push       = beat_in && (beat_cnt != real_len);
    assign beat_extra = beat_in && (beat_cnt == real_len);
    assign beat_stray = axi_rd_vld && (state != ST_BURST);

    assign rd_req    = (state == ST_REQ);
    assign rd_len    = rd_burst_len;
    assign dbg_state = state;

    sync_fifo #(
        .W     (AXI_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_ADDR_WIDTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (push),
        .wr_data  (axi_rd_data),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .full     (fifo_full),
        .empty    (rd_empty),
        .count    (rd_data_count),
        .wr_drop  (fifo_drop)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            beat_cnt   <= '0;
            rd_addr    <= rd_beg_addr;
            rd_ovf     <= 1'b0;
            rd_len_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Only ask for a burst the FIFO can fully absorb.
                    if (rd_mem_enable && (free >= (FIFO_ADDR_WIDTH+1)'(real_len))) begin
                        state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (rd_grant) begin
                        state    <= ST_BURST;
                        beat_cnt <= '0;
                    end
                end
                ST_BURST: begin
                    if (push) begin
                        beat_cnt <= beat_cnt + 9'd1;
                    end
                    if (axi_rd_done && rd_grant) begin
                        state   <= ST_IDLE;
                        rd_addr <= next_burst_addr(rd_addr, inc, rd_beg_addr, rd_end_addr);
                        if (beat_cnt != real_len) begin
                            rd_len_err <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (beat_extra || beat_stray) begin
                rd_len_err <= 1'b1;
            end
            if (fifo_drop) begin
                rd_ovf <= 1'b1;
            end
        end
    end

endmodule
